operand_decode: RTL and testbench

OPERAND_DECODE -- requirements
Module: operand_decode

---
 rtl/operand_decode_if.sv | 28 ++
 rtl/operand_decode.sv | 181 ++++++++++++++++++
 tb/tb_operand_decode.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_decode_if.sv
// Bundle between operand_decode and its neighbours: upstream handshake, register-file read port
// and the downstream handshake toward shift_unit. Names are as seen from operand_decode.
interface operand_decode_if;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        i_carry;
  logic [3:0]  o_rf_addr;
  logic [31:0] i_rf_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_op;
  logic [2:0]  o_type;
  logic [7:0]  o_amount;
  logic        o_carry;
  logic        o_undef;

  modport slave (
    input  i_valid, i_instr, i_pc, i_carry, i_rf_data, i_ready,
    output o_ready, o_rf_addr, o_valid, o_op, o_type, o_amount, o_carry, o_undef
  );

  modport master (
    output i_valid, i_instr, i_pc, i_carry, i_rf_data, i_ready,
    input  o_ready, o_rf_addr, o_valid, o_op, o_type, o_amount, o_carry, o_undef
  );
endinterface

// File: rtl/operand_decode.sv
// Decodes the shifter operand of an ARM data-processing instruction for shift_unit.
// Define REG_SHIFT_EN to support register-specified shifts; otherwise those forms flag o_undef.
//
// state | meaning
// IDLE  | ready for a new instruction, rf address follows i_instr[3:0]
// RD_RM | Rm read data arriving, rf address presents Rs
// RD_RS | Rs read data arriving (shift amount), REG_SHIFT_EN only
// OUT   | decoded operand valid, wait for i_ready
module operand_decode (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  operand_decode_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD_RM, S_RD_RS, S_OUT} state_e;

  localparam logic [2:0] T_LSL = 3'd0;
  localparam logic [2:0] T_LSR = 3'd1;
  localparam logic [2:0] T_ASR = 3'd2;
  localparam logic [2:0] T_ROR = 3'd3;
  localparam logic [2:0] T_RRX = 3'd4;
  localparam logic [2:0] T_BYP = 3'd7;

  state_e      state_q, state_d;
  logic [11:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] op_q, op_d;
  logic [2:0]  type_q, type_d;
  logic [7:0]  amount_q, amount_d;
  logic        carry_q, carry_d;
  logic        undef_q, undef_d;
  logic [3:0]  rf_addr_q;
  logic [3:0]  rf_addr;
  logic        ready;
  logic        valid;
  logic        accept;
  logic [31:0] rm_val;
  logic [1:0]  sh;
  logic [4:0]  imm_n;
  logic [3:0]  rot;
  logic        unused_instr;

  assign unused_instr = ^{bus.i_instr[31:26], bus.i_instr[24:12]};

  assign accept = (state_q == S_IDLE) && bus.i_valid && !i_flush;
  assign sh     = instr_q[6:5];
  assign imm_n  = instr_q[11:7];
  assign rot    = bus.i_instr[11:8];
  // PC reads as +8, or +12 when a register-specified shift costs the extra cycle
  assign rm_val = (instr_q[3:0] == 4'hF) ? (pc_q + (instr_q[4] ? 32'd12 : 32'd8)) : bus.i_rf_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.i_valid) state_d = bus.i_instr[25] ? S_OUT : S_RD_RM;
`ifdef REG_SHIFT_EN
        S_RD_RM: state_d = instr_q[4] ? S_RD_RS : S_OUT;
        S_RD_RS: state_d = S_OUT;
`else
        S_RD_RM: state_d = S_OUT;
`endif
        S_OUT:  if (bus.i_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready   = (state_q == S_IDLE);
    valid   = (state_q == S_OUT);
    rf_addr = rf_addr_q;
    case (state_q)
      S_IDLE:  rf_addr = bus.i_instr[3:0];
      S_RD_RM: rf_addr = instr_q[11:8];
      default: rf_addr = rf_addr_q;
    endcase
  end

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    op_d     = op_q;
    type_d   = type_q;
    amount_d = amount_q;
    carry_d  = carry_q;
    undef_d  = undef_q;
    if (accept) begin
      instr_d = bus.i_instr[11:0];
      pc_d    = bus.i_pc;
      carry_d = bus.i_carry;
      undef_d = 1'b0;
      if (bus.i_instr[25]) begin
        op_d = {24'b0, bus.i_instr[7:0]};
        if (rot == 4'd0) begin
          type_d   = T_BYP;
          amount_d = 8'd0;
        end else begin
          type_d   = T_ROR;
          amount_d = {3'b0, rot, 1'b0};
        end
      end
    end else if (state_q == S_RD_RM && !i_flush) begin
      op_d = rm_val;
      if (!instr_q[4]) begin
        // zero immediate amounts encode the 32-bit and RRX variants
        if (imm_n == 5'd0) begin
          case (sh)
            2'd0: begin type_d = T_BYP; amount_d = 8'd0;  end
            2'd1: begin type_d = T_LSR; amount_d = 8'd32; end
            2'd2: begin type_d = T_ASR; amount_d = 8'd32; end
            default: begin type_d = T_RRX; amount_d = 8'd0; end
          endcase
        end else begin
          type_d   = {1'b0, sh};
          amount_d = {3'b0, imm_n};
        end
      end else begin
`ifndef REG_SHIFT_EN
        undef_d  = 1'b1;
        type_d   = T_BYP;
        amount_d = 8'd0;
`endif
      end
    end
`ifdef REG_SHIFT_EN
    else if (state_q == S_RD_RS && !i_flush) begin
      if (bus.i_rf_data[7:0] == 8'd0) begin
        type_d   = T_BYP;
        amount_d = 8'd0;
      end else begin
        type_d   = {1'b0, sh};
        amount_d = bus.i_rf_data[7:0];
      end
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      instr_q   <= '0;
      pc_q      <= '0;
      op_q      <= '0;
      type_q    <= T_BYP;
      amount_q  <= '0;
      carry_q   <= 1'b0;
      undef_q   <= 1'b0;
      rf_addr_q <= '0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      type_q    <= type_d;
      amount_q  <= amount_d;
      carry_q   <= carry_d;
      undef_q   <= undef_d;
      rf_addr_q <= rf_addr;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_valid   = valid;
  assign bus.o_rf_addr = rf_addr;
  assign bus.o_op      = op_q;
  assign bus.o_type    = type_q;
  assign bus.o_amount  = amount_q;
  assign bus.o_carry   = carry_q;
  assign bus.o_undef   = undef_q;

endmodule

// File: tb/tb_operand_decode.sv
// Directed bench for operand_decode: hand-computed vectors, register file modelled with one-cycle read.
module tb_operand_decode;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  operand_decode_if bus ();

  operand_decode dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .bus     (bus)
  );

  logic [31:0] rf [16];
  always @(posedge clk) bus.i_rf_data <= rf[bus.o_rf_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic accept_only(input logic [31:0] instr, input logic [31:0] pc, input logic c,
                             output logic [3:0] a0, output logic [3:0] a1);
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_instr = instr;
    bus.i_pc    = pc;
    bus.i_carry = c;
    #1;
    check("ready_before_accept", {31'b0, bus.o_ready}, 32'd1);
    a0 = bus.o_rf_addr;
    @(negedge clk);
    bus.i_valid = 1'b0;
    a1 = bus.o_rf_addr;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic c,
                       output logic [3:0] a0, output logic [3:0] a1, output int lat);
    accept_only(instr, pc, c, a0, a1);
    lat = 1;
    while (!bus.o_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic expect_out(input string tag, input int lat, input int lat_exp,
                            input logic [31:0] op, input logic [2:0] ty, input logic [7:0] amt,
                            input logic cy, input logic ud);
    check({tag, "_lat"},   lat, lat_exp);
    check({tag, "_valid"}, {31'b0, bus.o_valid}, 32'd1);
    check({tag, "_op"},    bus.o_op, op);
    check({tag, "_type"},  {29'b0, bus.o_type}, {29'b0, ty});
    check({tag, "_amt"},   {24'b0, bus.o_amount}, {24'b0, amt});
    check({tag, "_carry"}, {31'b0, bus.o_carry}, {31'b0, cy});
    check({tag, "_undef"}, {31'b0, bus.o_undef}, {31'b0, ud});
  endtask

  task automatic release_out(input string tag);
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({tag, "_idle_valid"}, {31'b0, bus.o_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'b0, bus.o_ready}, 32'd1);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    check({tag, "_no_valid"}, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] a0, a1;
    int lat;

    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[1] = 32'h8000_0000;
    rf[2] = 32'h0000_0001;
    rf[3] = 32'h0000_0104;
    rf[4] = 32'hDEAD_BEEF;
    rf[5] = 32'h0000_0100;
    rf[6] = 32'h0000_00C8;
    rst = 1'b1;
    flush = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_instr = 32'h0;
    bus.i_pc = 32'h0;
    bus.i_carry = 1'b0;
    bus.i_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", {31'b0, bus.o_valid}, 32'd0);
    check("rst_ready", {31'b0, bus.o_ready}, 32'd1);
    check("rst_op", bus.o_op, 32'd0);
    check("rst_type", {29'b0, bus.o_type}, 32'd7);
    check("rst_amt", {24'b0, bus.o_amount}, 32'd0);
    check("rst_carry", {31'b0, bus.o_carry}, 32'd0);
    check("rst_undef", {31'b0, bus.o_undef}, 32'd0);
    check("rst_rf_addr", {28'b0, bus.o_rf_addr}, 32'd0);

    // MOV r0,#0xFF
    issue(32'hE3A000FF, 32'h0, 1'b1, a0, a1, lat);
    expect_out("imm_ff", lat, 1, 32'hFF, 3'd7, 8'd0, 1'b1, 1'b0);
    release_out("imm_ff");

    // rotated immediate, reset while presented, then re-issue
    issue(32'hE3A004FF, 32'h0, 1'b0, a0, a1, lat);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", {31'b0, bus.o_valid}, 32'd0);
    check("rst_mid_ready", {31'b0, bus.o_ready}, 32'd1);
    check("rst_mid_op", bus.o_op, 32'd0);
    check("rst_mid_type", {29'b0, bus.o_type}, 32'd7);
    issue(32'hE3A004FF, 32'h0, 1'b0, a0, a1, lat);
    expect_out("imm_rot4", lat, 1, 32'hFF, 3'd3, 8'd8, 1'b0, 1'b0);
    release_out("imm_rot4");

    issue(32'hE3A00F01, 32'h0, 1'b1, a0, a1, lat);
    expect_out("imm_rot15", lat, 1, 32'h1, 3'd3, 8'd30, 1'b1, 1'b0);
    release_out("imm_rot15");

    // LSR #0 -> LSR 32
    issue(32'hE1A00021, 32'h0, 1'b0, a0, a1, lat);
    check("lsr0_rf_addr", {28'b0, a0}, 32'd1);
    expect_out("lsr0", lat, 2, 32'h8000_0000, 3'd1, 8'd32, 1'b0, 1'b0);
    release_out("lsr0");

    issue(32'hE1A002C4, 32'h0, 1'b1, a0, a1, lat);
    expect_out("asr5", lat, 2, 32'hDEAD_BEEF, 3'd2, 8'd5, 1'b1, 1'b0);
    release_out("asr5");

    issue(32'hE1A00044, 32'h0, 1'b0, a0, a1, lat);
    expect_out("asr0", lat, 2, 32'hDEAD_BEEF, 3'd2, 8'd32, 1'b0, 1'b0);
    release_out("asr0");

    issue(32'hE1A00064, 32'h0, 1'b0, a0, a1, lat);
    expect_out("rrx", lat, 2, 32'hDEAD_BEEF, 3'd4, 8'd0, 1'b0, 1'b0);
    release_out("rrx");

    // LSL r2 by r3
    issue(32'hE1A00312, 32'h0, 1'b0, a0, a1, lat);
    check("regsh_addr_rm", {28'b0, a0}, 32'd2);
    check("regsh_addr_rs", {28'b0, a1}, 32'd3);
`ifdef REG_SHIFT_EN
    expect_out("regsh", lat, 3, 32'h1, 3'd0, 8'h04, 1'b0, 1'b0);
`else
    expect_out("regsh", lat, 2, 32'h1, 3'd7, 8'h00, 1'b0, 1'b1);
`endif
    release_out("regsh");

    // Rm = pc with register shift reads pc+12
    issue(32'hE1A0031F, 32'h2000, 1'b0, a0, a1, lat);
`ifdef REG_SHIFT_EN
    expect_out("regsh_pc", lat, 3, 32'h200C, 3'd0, 8'h04, 1'b0, 1'b0);
`else
    expect_out("regsh_pc", lat, 2, 32'h200C, 3'd7, 8'h00, 1'b0, 1'b1);
`endif
    release_out("regsh_pc");

    issue(32'hE1A00532, 32'h0, 1'b0, a0, a1, lat);
`ifdef REG_SHIFT_EN
    expect_out("regsh_zero", lat, 3, 32'h1, 3'd7, 8'd0, 1'b0, 1'b0);
`else
    expect_out("regsh_zero", lat, 2, 32'h1, 3'd7, 8'd0, 1'b0, 1'b1);
`endif
    release_out("regsh_zero");

    issue(32'hE1A00672, 32'h0, 1'b1, a0, a1, lat);
`ifdef REG_SHIFT_EN
    expect_out("regsh_200", lat, 3, 32'h1, 3'd3, 8'd200, 1'b1, 1'b0);
`else
    expect_out("regsh_200", lat, 2, 32'h1, 3'd7, 8'd0, 1'b1, 1'b1);
`endif
    release_out("regsh_200");

    // MOV r0,pc with downstream stall
    issue(32'hE1A0000F, 32'h1000, 1'b0, a0, a1, lat);
    expect_out("movpc", lat, 2, 32'h1008, 3'd7, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'b0, bus.o_valid}, 32'd1);
      check("stall_ready", {31'b0, bus.o_ready}, 32'd0);
      check("stall_op", bus.o_op, 32'h1008);
      check("stall_type", {29'b0, bus.o_type}, 32'd7);
      check("stall_amt", {24'b0, bus.o_amount}, 32'd0);
    end
    release_out("movpc");

    // reset during RD_RM discards the instruction
    accept_only(32'hE1A00021, 32'h0, 1'b0, a0, a1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rdrm_ready", {31'b0, bus.o_ready}, 32'd1);
    expect_quiet("rst_rdrm", 5);

    // flush in the last read state
    accept_only(32'hE1A00312, 32'h0, 1'b0, a0, a1);
`ifdef REG_SHIFT_EN
    @(negedge clk);
`endif
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", {31'b0, bus.o_ready}, 32'd1);
    check("flush_valid", {31'b0, bus.o_valid}, 32'd0);
    expect_quiet("flush", 5);

    // flush together with i_valid in IDLE: not accepted
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_instr = 32'hE3A000FF;
    flush = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_ready", {31'b0, bus.o_ready}, 32'd1);
    expect_quiet("flush_idle", 4);

    // back to normal after flushes
    issue(32'hE3A000FF, 32'h0, 1'b0, a0, a1, lat);
    expect_out("post_flush", lat, 1, 32'hFF, 3'd7, 8'd0, 1'b0, 1'b0);
    release_out("post_flush");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
